// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory bus arbiter: FSM encoding and
// ControlBus bit positions.
package mem_arb_pkg;

  localparam int   ST_W      = 2;
  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_ACCESS = 2'd1;
  localparam logic [ST_W-1:0] ST_ACK    = 2'd2;

  localparam int CB_W  = 3;
  localparam int CB_WR = 2;
  localparam int CB_RD = 1;

  localparam int WCNT_W = 3;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester handshakes plus the shared memory bus around the
// arbiter. master = arbiter view, slave = requesters/memory view.
interface mem_bus_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          m0_req, m1_req;
  logic          m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack;
  logic [AW-1:0] AddressBus;
  logic [DW-1:0] DataBusOut;
  logic [DW-1:0] DataBusIn;
  logic [2:0]    ControlBus;
  logic          grant_id;
  logic          busy;
  logic [31:0]   txn_count;

  modport master (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output m0_rdata, m1_rdata, m0_ack, m1_ack,
    output AddressBus, DataBusOut, ControlBus,
    input  DataBusIn,
    output grant_id, busy, txn_count
  );

  modport slave (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  m0_rdata, m1_rdata, m0_ack, m1_ack,
    input  AddressBus, DataBusOut, ControlBus,
    output DataBusIn,
    input  grant_id, busy, txn_count
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, on contention the port
// that did not win last time gets the bus.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  // one-hot grant from request vector and last winner
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between a CPU port (0) and a loader/debug port (1).
// Each transaction goes IDLE -> ACCESS (1 cycle write, RD_LAT cycles read)
// -> ACK (one-cycle pulse) -> IDLE, so grants are never back-to-back.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          InputClk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] AddressBus,
  output logic [DW-1:0] DataBusOut,
  input  logic [DW-1:0] DataBusIn,
  output logic [2:0]    ControlBus,
  output logic          grant_id,
  output logic          busy,
  output logic [31:0]   txn_count
);

  logic [ST_W-1:0]   state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [DW-1:0]     rdata0_q, rdata0_d;
  logic [DW-1:0]     rdata1_q, rdata1_d;
  logic [31:0]       txn_q, txn_d;
  logic [1:0]        rr_gnt;

  rr_arbiter2 u_rr (
    .req  ({m1_req, m0_req}),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // next-state: latch winner in IDLE, count read wait, count completions in ACK
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    txn_d    = txn_q;
    case (state_q)
      ST_IDLE: begin
        if (|rr_gnt) begin
          gnt_d   = rr_gnt[1];
          last_d  = rr_gnt[1];
          we_d    = rr_gnt[1] ? m1_we    : m0_we;
          addr_d  = rr_gnt[1] ? m1_addr  : m0_addr;
          wdata_d = rr_gnt[1] ? m1_wdata : m0_wdata;
          wcnt_d  = WCNT_W'(RD_LAT - 1);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_ACK;
        end else if (wcnt_q == '0) begin
          // last read cycle: memory data is valid now
          if (gnt_q) rdata1_d = DataBusIn;
          else       rdata0_d = DataBusIn;
          state_d = ST_ACK;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        txn_d   = txn_q + 32'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // registers; reset aborts any transaction in flight and favours port 0 next
  always_ff @(posedge InputClk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      txn_q    <= txn_d;
    end
  end

  // bus strobes only in ACCESS; address/data simply hold between transactions
  always_comb begin
    ControlBus        = '0;
    ControlBus[CB_WR] = (state_q == ST_ACCESS) &&  we_q;
    ControlBus[CB_RD] = (state_q == ST_ACCESS) && !we_q;
  end

  assign AddressBus = addr_q;
  assign DataBusOut = wdata_q;
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;
  assign m0_ack     = (state_q == ST_ACK) && !gnt_q;
  assign m1_ack     = (state_q == ST_ACK) &&  gnt_q;
  assign grant_id   = gnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign txn_count  = txn_q;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data bus width (matches `BIT_WIDTH`).
REQ-002 SHALL have parameter AW, default 32, address bus width.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1..7, memory read latency in cycles.
REQ-004 SHALL have port InputClk  input  1  single system clock, all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports mN_req  input  1  access request from requester N (N=0 CPU, N=1 loader/debug).
REQ-007 SHALL have ports mN_we  input  1  1=write, 0=read.
REQ-008 SHALL have ports mN_addr  input  AW  access address.
REQ-009 SHALL have ports mN_wdata  input  DW  write data.
REQ-010 SHALL have ports mN_rdata  output  DW  read data, valid while mN_ack=1.
REQ-011 SHALL have ports mN_ack  output  1  one-cycle completion pulse.
REQ-012 SHALL have port AddressBus  output  AW  shared memory address.
REQ-013 SHALL have port DataBusOut  output  DW  shared memory write data.
REQ-014 SHALL have port DataBusIn  input  DW  shared memory read data.
REQ-015 SHALL have port ControlBus  output  3  [2]=MemWriteEn, [1]=MemReadEn, [0]=reserved, always 0.
REQ-016 SHALL have port grant_id  output  1  requester owning the bus; valid while busy=1.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port txn_count  output  32  completed transactions since reset; wraps at 2^32.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, ACK.
REQ-020 IDLE, at an edge with any mN_req=1: SHALL latch winner's we/addr/wdata, set grant_id, go to ACCESS.
REQ-021 Arbitration SHALL be round-robin: if both request, the port not granted last wins; if one requests, it wins.
REQ-022 ACCESS SHALL drive AddressBus/DataBusOut from latched values; ControlBus=3'b100 (write) or 3'b010 (read).
REQ-023 A write SHALL stay in ACCESS exactly 1 cycle; a read SHALL stay exactly RD_LAT cycles, counted by a wait counter.
REQ-024 On the last read ACCESS cycle, DataBusIn SHALL be captured into the granted port's rdata register.
REQ-025 ACK SHALL last 1 cycle: mN_ack=1 for granted port only, ControlBus=0, txn_count increments; then IDLE.
REQ-026 Latency SHALL be: req sampled at edge k, ack high in cycle k+2 (write) or k+1+RD_LAT (read).
REQ-027 Requests SHALL NOT be sampled in ACCESS or ACK; no back-to-back grant without an IDLE cycle.
REQ-028 A requester deasserting mN_req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-029 Requesters SHALL hold req and payload stable until ack; changes after latching SHALL be ignored.
REQ-030 Outside ACCESS, ControlBus SHALL be 3'b000 and AddressBus/DataBusOut SHALL hold their last value.
REQ-031 mN_rdata SHALL hold its last captured value until the next read on that port.

Reset
REQ-032 With rst=0 at an edge: state=IDLE, ControlBus=0, AddressBus=0, DataBusOut=0, mN_rdata=0, mN_ack=0, grant_id=0, busy=0, txn_count=0, round-robin favours port 0.
REQ-033 Reset mid-transaction SHALL abort it: no ack, no count increment, ControlBus=0 the next cycle.

Structure
REQ-034 Shared package mem_arb_pkg SHALL hold the FSM state encoding and the ControlBus bit-index constants (CB_WR=2, CB_RD=1).
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter2 (2 requests, last-grant input, one-hot grant output).

Verification
REQ-036 Write from m0: addr 0x10, data 0xDEADBEEF -> ControlBus=100 for 1 cycle; m0_ack at k+2; memory[0x10]=0xDEADBEEF.
REQ-037 Read from m1 with RD_LAT=1 of 0x10 -> ControlBus=010 for 1 cycle; m1_ack at k+2 with m1_rdata=0xDEADBEEF.
REQ-038 Both request continuously from reset -> grants alternate 0,1,0,1; txn_count=4 after 4 acks.
REQ-039 m0 drops req one cycle after grant -> transaction completes; m0_ack pulses once; m1 never acked.
REQ-040 rst=0 asserted during a read ACCESS with RD_LAT=3 -> no ack; ControlBus=0 next cycle; txn_count=0; next request is granted normally.
